// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a busy-bit scoreboard.
// Two combinational read ports, one write port and an issue port that
// marks destinations pending. Entry 0 always reads zero and is never busy.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to both read
// ports and lets that write clear an issue hazard.
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int CW    = AW + 1
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [AW-1:0]    Ra,
    input  logic [AW-1:0]    Rb,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb,
    output logic             Ra_rdy,
    output logic             Rb_rdy,
    input  logic             We,
    input  logic [AW-1:0]    Wr,
    input  logic [WIDTH-1:0] D,
    input  logic             Iss,
    input  logic [AW-1:0]    Iss_rd,
    output logic             Iss_ok,
    output logic [CW-1:0]    Busy_cnt
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [CW-1:0]    r_cnt;
    logic             w_we;
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic             w_fwd_i;
    logic             w_iss_set;
    logic             w_dec;

    // Writes to entry 0 are dropped so it stays zero forever.
    assign w_we = We & (Wr != '0);

`ifdef REGFILE_BYPASS_EN
    assign w_fwd_a = w_we & (Wr == Ra);
    assign w_fwd_b = w_we & (Wr == Rb);
    assign w_fwd_i = w_we & (Wr == Iss_rd);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
    assign w_fwd_i = 1'b0;
`endif

    assign Qa     = (Ra == '0) ? '0 : (w_fwd_a ? D : r_mem[Ra]);
    assign Qb     = (Rb == '0) ? '0 : (w_fwd_b ? D : r_mem[Rb]);
    assign Ra_rdy = ~r_busy[Ra] | w_fwd_a;
    assign Rb_rdy = ~r_busy[Rb] | w_fwd_b;

    // A same-cycle write only clears the hazard when forwarding is built in.
    assign Iss_ok    = Iss & ((Iss_rd == '0) | ~r_busy[Iss_rd] | w_fwd_i);
    assign w_iss_set = Iss_ok & (Iss_rd != '0);
    assign w_dec     = w_we & r_busy[Wr];
    assign Busy_cnt  = r_cnt;

    // Data storage: cleared on reset, written on enabled nonzero address.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[Wr] <= D;
        end
    end

    // Busy bits: a write clears, an accepted issue sets; the issue is last so it wins.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_busy <= '0;
        end else begin
            if (w_we) r_busy[Wr] <= 1'b0;
            if (w_iss_set) r_busy[Iss_rd] <= 1'b1;
        end
    end

    // Pending count tracks set/clear events of the busy bits on the same edge.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) r_cnt <= '0;
        else r_cnt <= r_cnt + CW'(w_iss_set) - CW'(w_dec);
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against a behavioural model.
module tb_regfile_sb;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int CW    = 6;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Clrn = 1'b0;
    logic [AW-1:0]    Ra = '0, Rb = '0, Wr = '0, Iss_rd = '0;
    logic [WIDTH-1:0] D = '0;
    logic             We = 1'b0, Iss = 1'b0;
    logic [WIDTH-1:0] Qa, Qb;
    logic             Ra_rdy, Rb_rdy, Iss_ok;
    logic [CW-1:0]    Busy_cnt;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_busy [DEPTH];

    regfile_sb #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) dut (
        .Clk(Clk), .Clrn(Clrn), .Ra(Ra), .Rb(Rb), .Qa(Qa), .Qb(Qb),
        .Ra_rdy(Ra_rdy), .Rb_rdy(Rb_rdy), .We(We), .Wr(Wr), .D(D),
        .Iss(Iss), .Iss_rd(Iss_rd), .Iss_ok(Iss_ok), .Busy_cnt(Busy_cnt)
    );

    always #5 Clk = ~Clk;

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic bit m_fwd(input logic [AW-1:0] a);
        return BYP && We && a != 0 && Wr == a;
    endfunction

    function automatic logic [WIDTH-1:0] m_q(input logic [AW-1:0] a);
        if (a == 0) return '0;
        return m_fwd(a) ? D : m_mem[a];
    endfunction

    function automatic bit m_rdy(input logic [AW-1:0] a);
        return !m_busy[a] || m_fwd(a);
    endfunction

    function automatic bit m_ok();
        return Iss && (Iss_rd == 0 || !m_busy[Iss_rd] || m_fwd(Iss_rd));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive(input bit we, input logic [AW-1:0] wr, input logic [WIDTH-1:0] d,
                         input bit iss, input logic [AW-1:0] ird,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        We = we; Wr = wr; D = d; Iss = iss; Iss_rd = ird; Ra = ra; Rb = rb;
        #1;
    endtask

    task automatic tick();
        bit ok;
        @(posedge Clk);
        ok = m_ok();
        if (We && Wr != 0) begin
            m_mem[Wr] = D;
            m_busy[Wr] = 1'b0;
        end
        if (ok && Iss_rd != 0) m_busy[Iss_rd] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        Clrn = 1'b0;
        m_clear();
        #1;
        Clrn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        m_clear();
        #2;
        checks++;
        if (Busy_cnt !== 0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d exp=0", Busy_cnt);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, AW'(i), AW'(DEPTH - 1 - i));
            checks++;
            if (Qa !== 0 || Qb !== 0 || Ra_rdy !== 1'b1 || Rb_rdy !== 1'b1) begin
                failures++;
                $display("FAIL reset_read addr=%0d got qa=%h qb=%h rdy=%b%b exp 0 0 11", i, Qa, Qb, Ra_rdy, Rb_rdy);
            end
        end
        @(negedge Clk);
        Clrn = 1'b1;
        #1;
        drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        checks++;
        if (Qa !== 0) begin
            failures++;
            $display("FAIL zero_fwd got=%h exp=0", Qa);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (Qa !== 0 || Ra_rdy !== 1'b1) begin
            failures++;
            $display("FAIL zero_write got=%h rdy=%b exp=0 rdy=1", Qa, Ra_rdy);
        end
    endtask

    task automatic test_basic_rw();
        do_reset();
        drive(1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 7, 7);
        checks++;
        if (Qa !== 32'hDEAD_BEEF || Qb !== 32'hDEAD_BEEF || Ra_rdy !== 1'b1 || Rb_rdy !== 1'b1) begin
            failures++;
            $display("FAIL basic_rw got qa=%h qb=%h rdy=%b%b exp deadbeef deadbeef 11", Qa, Qb, Ra_rdy, Rb_rdy);
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        drive(0, 0, 0, 1, 5, 5, 0);
        checks++;
        if (Iss_ok !== 1'b1) begin
            failures++;
            $display("FAIL sb_issue_ok got=%b exp=1", Iss_ok);
        end
        tick();
        drive(0, 0, 0, 0, 0, 5, 0);
        checks++;
        if (Ra_rdy !== 1'b0 || Busy_cnt !== 1) begin
            failures++;
            $display("FAIL sb_set got rdy=%b cnt=%0d exp rdy=0 cnt=1", Ra_rdy, Busy_cnt);
        end
        drive(0, 0, 0, 1, 5, 5, 0);
        checks++;
        if (Iss_ok !== 1'b0) begin
            failures++;
            $display("FAIL sb_reissue got=%b exp=0", Iss_ok);
        end
        tick();
        checks++;
        if (Busy_cnt !== 1) begin
            failures++;
            $display("FAIL sb_reissue_cnt got=%0d exp=1", Busy_cnt);
        end
        drive(1, 5, 32'h1234, 0, 0, 5, 0);
        tick();
        drive(0, 0, 0, 0, 0, 5, 0);
        checks++;
        if (Ra_rdy !== 1'b1 || Busy_cnt !== 0 || Qa !== 32'h1234) begin
            failures++;
            $display("FAIL sb_clear got rdy=%b cnt=%0d qa=%h exp 1 0 1234", Ra_rdy, Busy_cnt, Qa);
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (Iss_ok !== 1'b1) begin
            failures++;
            $display("FAIL sb_issue_zero got=%b exp=1", Iss_ok);
        end
        tick();
        checks++;
        if (Busy_cnt !== 0 || Ra_rdy !== 1'b1) begin
            failures++;
            $display("FAIL sb_issue_zero_cnt got cnt=%0d rdy=%b exp 0 1", Busy_cnt, Ra_rdy);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(1, 9, 32'hA5, 1, 9, 0, 0);
        checks++;
        if (Iss_ok !== 1'b1) begin
            failures++;
            $display("FAIL sim_same_ok got=%b exp=1", Iss_ok);
        end
        tick();
        drive(0, 0, 0, 0, 0, 9, 0);
        checks++;
        if (Qa !== 32'hA5 || Ra_rdy !== 1'b0 || Busy_cnt !== 1) begin
            failures++;
            $display("FAIL sim_same got qa=%h rdy=%b cnt=%0d exp a5 0 1", Qa, Ra_rdy, Busy_cnt);
        end
        drive(0, 0, 0, 1, 3, 0, 0);
        tick();
        drive(1, 3, 32'h33, 1, 4, 3, 4);
        tick();
        drive(0, 0, 0, 0, 0, 3, 4);
        checks++;
        if (Busy_cnt !== 2 || Ra_rdy !== 1'b1 || Rb_rdy !== 1'b0 || Qa !== 32'h33) begin
            failures++;
            $display("FAIL sim_diff got cnt=%0d rdy=%b%b qa=%h exp 2 10 33", Busy_cnt, Ra_rdy, Rb_rdy, Qa);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 1, AW'(i), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (Busy_cnt !== 3) begin
            failures++;
            $display("FAIL mid_pre got=%0d exp=3", Busy_cnt);
        end
        Clrn = 1'b0;
        m_clear();
        #1;
        checks++;
        if (Busy_cnt !== 0) begin
            failures++;
            $display("FAIL mid_cnt got=%0d exp=0", Busy_cnt);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 0, AW'(i), AW'(i));
            checks++;
            if (Ra_rdy !== 1'b1 || Rb_rdy !== 1'b1) begin
                failures++;
                $display("FAIL mid_rdy addr=%0d got=%b%b exp=11", i, Ra_rdy, Rb_rdy);
            end
        end
        Clrn = 1'b1;
        #1;
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1, 6, 32'h77, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 6, 0, 0);
        tick();
        drive(1, 6, 32'h55AA, 0, 0, 6, 6);
        checks++;
        if (Qa !== (BYP ? 32'h55AA : 32'h77) || Ra_rdy !== BYP || Qb !== (BYP ? 32'h55AA : 32'h77)) begin
            failures++;
            $display("FAIL bypass_read got qa=%h qb=%h rdy=%b exp qa=%h rdy=%b", Qa, Qb, Ra_rdy, BYP ? 32'h55AA : 32'h77, BYP);
        end
        drive(1, 6, 32'h55AA, 1, 6, 6, 6);
        checks++;
        if (Iss_ok !== BYP) begin
            failures++;
            $display("FAIL bypass_issue got=%b exp=%b", Iss_ok, BYP);
        end
        tick();
        drive(0, 0, 0, 0, 0, 6, 0);
        checks++;
        if (Qa !== 32'h55AA || Ra_rdy !== !BYP || Busy_cnt !== CW'(BYP ? 1 : 0)) begin
            failures++;
            $display("FAIL bypass_after got qa=%h rdy=%b cnt=%0d exp 55aa %b %0d", Qa, Ra_rdy, Busy_cnt, !BYP, BYP ? 1 : 0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            checks++;
            if (Qa !== m_q(Ra) || Qb !== m_q(Rb)) begin
                failures++;
                $display("FAIL rnd_q n=%0d got qa=%h qb=%h exp %h %h", n, Qa, Qb, m_q(Ra), m_q(Rb));
            end
            checks++;
            if (Ra_rdy !== m_rdy(Ra) || Rb_rdy !== m_rdy(Rb)) begin
                failures++;
                $display("FAIL rnd_rdy n=%0d got=%b%b exp=%b%b", n, Ra_rdy, Rb_rdy, m_rdy(Ra), m_rdy(Rb));
            end
            checks++;
            if (Iss_ok !== m_ok()) begin
                failures++;
                $display("FAIL rnd_ok n=%0d got=%b exp=%b", n, Iss_ok, m_ok());
            end
            checks++;
            if (int'(Busy_cnt) !== m_cnt()) begin
                failures++;
                $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, Busy_cnt, m_cnt());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_scoreboard();
        test_simultaneous();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
